// File: rtl/ro_mon_pkg.sv
// Shared definitions for the readout-timeout monitor: FSM encoding,
// default sizes and the legacy channel ordering.
package ro_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TMO  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int NCH_D = 7;   // ALCT, TMB, CFEB1-5
  localparam int TW_D  = 12;  // timeout timer width
  localparam int CW_D  = 8;   // per-channel error counter width

  // Legacy channel bit positions in the OE / DATANOEND vectors
  localparam int CH_CFEB1 = 0;
  localparam int CH_CFEB2 = 1;
  localparam int CH_CFEB3 = 2;
  localparam int CH_CFEB4 = 3;
  localparam int CH_CFEB5 = 4;
  localparam int CH_TMB   = 5;
  localparam int CH_ALCT  = 6;

endpackage

// File: rtl/ro_tmo_mon_if.sv
// Control/status bundle of the readout-timeout monitor. The master side
// drives OE and configuration, the slave side (the monitor) reports status.
interface ro_tmo_mon_if
  import ro_mon_pkg::*;
#(
  parameter int NCH = NCH_D,
  parameter int TW  = TW_D,
  parameter int CW  = CW_D
);
  logic [NCH-1:0]    OE;
  logic [TW-1:0]     TMO_LIMIT;
  logic              RETRIG;
  logic              CNT_CLR;
  logic              TMO_PULSE;
  logic [NCH-1:0]    DATANOEND;
  logic              TMO_ANY;
  logic [NCH*CW-1:0] ERR_CNT;
  logic [1:0]        STATE;

  modport master (
    output OE, TMO_LIMIT, RETRIG, CNT_CLR,
    input  TMO_PULSE, DATANOEND, TMO_ANY, ERR_CNT, STATE
  );

  modport slave (
    input  OE, TMO_LIMIT, RETRIG, CNT_CLR,
    output TMO_PULSE, DATANOEND, TMO_ANY, ERR_CNT, STATE
  );
endinterface

// File: rtl/sync2_bus.sv
// Generic 2-flop level synchroniser into the CLKCMS domain. Bits are
// synchronised independently, so only use it for slowly changing levels.
module sync2_bus #(
  parameter int W = 1
) (
  input  logic         CLKCMS,
  input  logic         pop_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  // two back-to-back flops, both cleared by reset
  always_ff @(posedge CLKCMS or posedge pop_rst)
    if (pop_rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/ro_tmo_mon.sv
// Per-channel readout-timeout monitor. Times how long the synchronised
// OE vector stays nonzero and unchanged; a stall of TMO_LIMIT cycles
// flags the active channels in DATANOEND and bumps their error counters.
module ro_tmo_mon
  import ro_mon_pkg::*;
#(
  parameter int NCH = NCH_D,
  parameter int TW  = TW_D,
  parameter int CW  = CW_D
) (
  input logic         CLKCMS,
  input logic         pop_rst,
  ro_tmo_mon_if.slave bus
);
  logic [NCH-1:0]          oe_s, oe_q;
  logic                    chg;
  logic [TW-1:0]           timer;
  state_t                  state;
  logic                    tmo_pulse, tmo_any;
  logic [NCH-1:0]          dne, dne_q;
  logic [NCH-1:0][CW-1:0]  err_cnt;

  sync2_bus #(.W(NCH)) u_sync (
    .CLKCMS  (CLKCMS),
    .pop_rst (pop_rst),
    .d       (bus.OE),
    .q       (oe_s)
  );

  // previous synchronised OE, used to detect channel handoff
  always_ff @(posedge CLKCMS or posedge pop_rst)
    if (pop_rst) oe_q <= '0;
    else         oe_q <= oe_s;

  assign chg = (oe_s != oe_q);

  // timeout FSM with timer; pulse/flags are registered on the RUN->TMO edge
  always_ff @(posedge CLKCMS or posedge pop_rst)
    if (pop_rst) begin
      state     <= IDLE;
      timer     <= '0;
      dne       <= '0;
      tmo_any   <= 1'b0;
      tmo_pulse <= 1'b0;
    end else begin
      tmo_pulse <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (oe_s != '0 && bus.TMO_LIMIT != '0) state <= RUN;
        end
        RUN: begin
          if (oe_s == '0 || bus.TMO_LIMIT == '0) begin
            state <= IDLE;
            timer <= '0;
          end else if (chg) begin
            timer <= '0;
          end else if (timer == bus.TMO_LIMIT - 1'b1) begin
            // oe_s here is the captured set of stalled channels
            state     <= TMO;
            timer     <= '0;
            dne       <= dne | oe_s;
            tmo_any   <= 1'b1;
            tmo_pulse <= 1'b1;
          end else if (timer != '1) begin
            // hold at max so a lowered limit can never be hit by wrap-around
            timer <= timer + 1'b1;
          end
        end
        TMO: begin
          timer <= '0;
          if (!bus.RETRIG)    state <= HOLD;
          else if (oe_s != '0) state <= RUN;
          else                 state <= IDLE;
        end
        HOLD:    timer <= '0;
        default: state <= IDLE;
      endcase
    end

  // delayed DATANOEND for rising-edge detection
  always_ff @(posedge CLKCMS or posedge pop_rst)
    if (pop_rst) dne_q <= '0;
    else         dne_q <= dne;

  // saturating error counters; intentionally outside pop_rst so they span events
  always_ff @(posedge CLKCMS)
    for (int i = 0; i < NCH; i++)
      if (bus.CNT_CLR)
        err_cnt[i] <= '0;
      else if (dne[i] && !dne_q[i] && err_cnt[i] != '1)
        err_cnt[i] <= err_cnt[i] + 1'b1;

  assign bus.TMO_PULSE = tmo_pulse;
  assign bus.DATANOEND = dne;
  assign bus.TMO_ANY   = tmo_any;
  assign bus.ERR_CNT   = err_cnt;
  assign bus.STATE     = state;
endmodule

// File: tb/tb_ro_tmo_mon.sv
// Directed bench for ro_tmo_mon: a vector table of single-event scenarios
// plus hand-written multi-cycle sequences. Edges are counted from the first
// edge that samples the new OE value (edge 1).
module tb_ro_tmo_mon;
  import ro_mon_pkg::*;

  logic CLKCMS = 1'b0;
  logic pop_rst;
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;

  always #5 CLKCMS = ~CLKCMS;

  ro_tmo_mon_if #(.NCH(7), .TW(12), .CW(8)) bus ();
  ro_tmo_mon_if #(.NCH(7), .TW(12), .CW(2)) bus2 ();

  assign bus2.OE        = bus.OE;
  assign bus2.TMO_LIMIT = bus.TMO_LIMIT;
  assign bus2.RETRIG    = bus.RETRIG;
  assign bus2.CNT_CLR   = bus.CNT_CLR;

  ro_tmo_mon #(.NCH(7), .TW(12), .CW(8)) dut (
    .CLKCMS(CLKCMS), .pop_rst(pop_rst), .bus(bus));

  ro_tmo_mon #(.NCH(7), .TW(12), .CW(2)) dut2 (
    .CLKCMS(CLKCMS), .pop_rst(pop_rst), .bus(bus2));

  typedef struct {
    logic [6:0]  oe;
    logic [11:0] lim;
    logic        rt;
    int          ncyc;
    int          np;     // expected pulse count
    int          first;  // expected first pulse edge (0 = none)
    int          last;   // expected last pulse edge
    logic [6:0]  dne;
    logic [1:0]  st;     // state after ncyc edges
    logic [63:0] err;    // ERR_CNT after ncyc edges
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKCMS);
    #1;
    edge_n++;
  endtask

  task automatic do_rst();
    bus.OE  = '0;
    pop_rst = 1'b1;
    step();
    pop_rst = 1'b0;
  endtask

  task automatic clr_cnt();
    bus.CNT_CLR = 1'b1;
    step();
    bus.CNT_CLR = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int np, fe, le;
    do_rst();
    bus.TMO_LIMIT = v.lim;
    bus.RETRIG    = v.rt;
    clr_cnt();
    bus.OE = v.oe;
    edge_n = 0; np = 0; fe = 0; le = 0;
    for (int c = 0; c < v.ncyc; c++) begin
      step();
      if (bus.TMO_PULSE) begin
        np++;
        if (fe == 0) fe = edge_n;
        le = edge_n;
      end
    end
    chk($sformatf("v%0d npulse", idx), 64'(np), 64'(v.np));
    chk($sformatf("v%0d first", idx), 64'(fe), 64'(v.first));
    chk($sformatf("v%0d last", idx), 64'(le), 64'(v.last));
    chk($sformatf("v%0d dne", idx), 64'(bus.DATANOEND), 64'(v.dne));
    chk($sformatf("v%0d any", idx), 64'(bus.TMO_ANY), 64'(v.dne != 0));
    chk($sformatf("v%0d state", idx), 64'(bus.STATE), 64'(v.st));
    chk($sformatf("v%0d err", idx), 64'(bus.ERR_CNT), v.err);
  endtask

  initial begin
    int np;
    vecs[0] = '{7'h01, 12'd100,  1'b0, 300,  1, 103,  103,  7'h01, HOLD, 64'd1};
    vecs[1] = '{7'h04, 12'd50,   1'b1, 200,  3, 53,   155,  7'h04, RUN,  64'd1 << 16};
    vecs[2] = '{7'h7f, 12'd0,    1'b0, 5000, 0, 0,    0,    7'h00, IDLE, 64'd0};
    vecs[3] = '{7'h10, 12'd1,    1'b0, 10,   1, 4,    4,    7'h10, HOLD, 64'd1 << 32};
    vecs[4] = '{7'h60, 12'd4095, 1'b0, 4200, 1, 4098, 4098, 7'h60, HOLD, (64'd1 << 40) | (64'd1 << 48)};
    vecs[5] = '{7'h03, 12'd2,    1'b1, 12,   3, 5,    11,   7'h03, RUN,  64'h101};

    bus.OE = '0; bus.TMO_LIMIT = '0; bus.RETRIG = 1'b0; bus.CNT_CLR = 1'b0;
    pop_rst = 1'b1;
    #12;
    // reset state
    chk("rst state", 64'(bus.STATE), 64'(IDLE));
    chk("rst pulse", 64'(bus.TMO_PULSE), 64'd0);
    chk("rst dne", 64'(bus.DATANOEND), 64'd0);
    chk("rst any", 64'(bus.TMO_ANY), 64'd0);
    pop_rst = 1'b0;
    clr_cnt();
    chk("clr err", 64'(bus.ERR_CNT), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // pop_rst at RUN timer=40: ERR_CNT left from the last vector survives
    do_rst();
    bus.TMO_LIMIT = 12'd100; bus.RETRIG = 1'b0; bus.OE = 7'h01;
    for (int c = 0; c < 43; c++) step();
    chk("midrst run", 64'(bus.STATE), 64'(RUN));
    #2 pop_rst = 1'b1;
    #1;
    chk("midrst state", 64'(bus.STATE), 64'(IDLE));
    chk("midrst dne", 64'(bus.DATANOEND), 64'd0);
    chk("midrst err", 64'(bus.ERR_CNT), 64'h101);
    step();
    pop_rst = 1'b0;

    // channel handoff keeps restarting the timer
    do_rst();
    bus.TMO_LIMIT = 12'd100; bus.RETRIG = 1'b0;
    np = 0;
    bus.OE = 7'h01;
    for (int c = 0; c < 80; c++) begin step(); if (bus.TMO_PULSE) np++; end
    bus.OE = 7'h02;
    for (int c = 0; c < 80; c++) begin step(); if (bus.TMO_PULSE) np++; end
    bus.OE = 7'h00;
    for (int c = 0; c < 6; c++) begin step(); if (bus.TMO_PULSE) np++; end
    chk("handoff pulses", 64'(np), 64'd0);
    chk("handoff dne", 64'(bus.DATANOEND), 64'd0);
    chk("handoff state", 64'(bus.STATE), 64'(IDLE));

    // limit=1 with chg on the compare cycle, then OE drops: no timeout
    do_rst();
    bus.TMO_LIMIT = 12'd1; bus.RETRIG = 1'b0;
    edge_n = 0; np = 0;
    bus.OE = 7'h10; step();
    bus.OE = 7'h18; step();
    bus.OE = 7'h00;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.TMO_PULSE) np++;
      if (edge_n == 4) chk("chg@lim state", 64'(bus.STATE), 64'(RUN));
    end
    chk("chg@lim pulses", 64'(np), 64'd0);
    chk("chg@lim state end", 64'(bus.STATE), 64'(IDLE));

    // limit lowered below the running timer: no timeout
    do_rst();
    bus.TMO_LIMIT = 12'd100; bus.OE = 7'h01; np = 0;
    for (int c = 0; c < 53; c++) step();
    bus.TMO_LIMIT = 12'd20;
    for (int c = 0; c < 300; c++) begin step(); if (bus.TMO_PULSE) np++; end
    chk("lowlim pulses", 64'(np), 64'd0);
    chk("lowlim state", 64'(bus.STATE), 64'(RUN));

    // saturation on the CW=2 instance, channel ALCT
    clr_cnt();
    bus.TMO_LIMIT = 12'd10;
    for (int k = 1; k <= 4; k++) begin
      do_rst();
      bus.OE = 7'h40;
      for (int c = 0; c < 20; c++) step();
      chk($sformatf("sat ev%0d", k), 64'(bus2.ERR_CNT[13:12]), 64'(k > 3 ? 3 : k));
    end
    chk("sat cw8", 64'(bus.ERR_CNT[55:48]), 64'd4);

    // fifth event: CNT_CLR on the increment edge (edge 14) wins
    do_rst();
    bus.OE = 7'h40; edge_n = 0;
    for (int c = 0; c < 13; c++) step();
    chk("ev5 pulse", 64'(bus.TMO_PULSE), 64'd1);
    bus.CNT_CLR = 1'b1;
    step();
    bus.CNT_CLR = 1'b0;
    chk("clr wins cw8", 64'(bus.ERR_CNT[55:48]), 64'd0);
    chk("clr wins cw2", 64'(bus2.ERR_CNT[13:12]), 64'd0);
    for (int c = 0; c < 5; c++) step();
    chk("clr hold", 64'(bus.ERR_CNT), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
